// File: rtl/ps2_keycode_rx.sv
// ps2_keycode_rx
//   Receives device-clocked PS/2 keyboard frames (start, 8 data bits LSB
//   first, odd parity, stop) and presents the last two good bytes as a
//   16-bit keycode {previous_byte, latest_byte}. Make codes therefore
//   appear as 16'h00xx after reset and break sequences as 16'hF0xx.
//   Runs entirely in the clk (pixel clock) domain; receive only, the PS/2
//   lines are never driven.
//
// Optional feature macro: PS2_TIMEOUT_EN
//   When defined, a partial frame that sees no falling edge for
//   TIMEOUT_CYCLES clocks is discarded with a frame_err pulse.
//   When undefined, a stalled partial frame waits until rst.
//
// Parameters
//   FILTER_LEN      consecutive equal samples of synced ps2_clk needed to
//                   accept a level change (>= 2)
//   TIMEOUT_CYCLES  idle cycles before a partial frame is dropped
//                   (PS2_TIMEOUT_EN only)
//
// Ports
//   clk        in   system / pixel clock
//   rst        in   synchronous, active-high reset
//   ps2_clk    in   raw PS/2 clock pin (asynchronous, idle high)
//   ps2_data   in   raw PS/2 data pin (asynchronous, idle high)
//   keycode    out  {byte[n-1], byte[n]} of the last two good frames
//   rx_valid   out  1-cycle pulse: keycode just updated
//   frame_err  out  1-cycle pulse: frame dropped
module ps2_keycode_rx #(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 65000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [15:0] keycode,
  output logic        rx_valid,
  output logic        frame_err
);

  localparam int unsigned FW = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  // ---------------------------------------------------------------------
  // Input synchronizers (reset to the idle-high bus level)
  // ---------------------------------------------------------------------
  logic [1:0] clk_sync;
  logic [1:0] data_sync;
  logic       clk_s;
  logic       data_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync  <= '1;
      data_sync <= '1;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  assign clk_s  = clk_sync[1];
  assign data_s = data_sync[1];

  // ---------------------------------------------------------------------
  // Clock glitch filter
  //   fcnt counts consecutive samples that disagree with the filtered
  //   level. The FILTER_LEN-th disagreeing sample flips the level; fe is
  //   asserted in that same cycle so the FSM samples data_s alongside it.
  // ---------------------------------------------------------------------
  logic          clk_filt;
  logic [FW-1:0] fcnt;
  logic          flip;
  logic          fe;

  assign flip = (clk_s != clk_filt) && (fcnt == FW'(FILTER_LEN - 1));
  assign fe   = flip && clk_filt;

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_filt <= 1'b1;
      fcnt     <= '0;
    end else if (clk_s == clk_filt) begin
      fcnt <= '0;
    end else if (flip) begin
      clk_filt <= clk_s;
      fcnt     <= '0;
    end else begin
      fcnt <= fcnt + FW'(1);
    end
  end

  // ---------------------------------------------------------------------
  // Frame FSM, shift register and registered outputs
  // ---------------------------------------------------------------------
  state_t     state;
  logic [2:0] cnt;
  logic [7:0] sh;
  logic       par;

`ifdef PS2_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt;
`else
  // TIMEOUT_CYCLES only matters when the timeout is compiled in.
  if (TIMEOUT_CYCLES == 0) begin : g_timeout_unused
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      sh        <= '0;
      par       <= 1'b0;
      keycode   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
`ifdef PS2_TIMEOUT_EN
      tcnt      <= '0;
`endif
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;

      if (fe) begin
        case (state)
          IDLE: begin
            // A high data line here is a spurious edge, silently ignored.
            if (!data_s) begin
              state <= DATA;
              cnt   <= '0;
            end
          end
          DATA: begin
            sh  <= {data_s, sh[7:1]};
            cnt <= cnt + 3'd1;
            if (cnt == 3'd7) begin
              state <= PARITY;
            end
          end
          PARITY: begin
            par   <= data_s;
            state <= STOP;
          end
          STOP: begin
            if (data_s && (^{sh, par})) begin
              keycode  <= {keycode[7:0], sh};
              rx_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
`ifdef PS2_TIMEOUT_EN
      // fe takes priority: the counter restarts on every accepted edge.
      else if (state != IDLE && tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
        state     <= IDLE;
        cnt       <= '0;
        frame_err <= 1'b1;
      end

      if (fe || state == IDLE) begin
        tcnt <= '0;
      end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
        tcnt <= '0;
      end else begin
        tcnt <= tcnt + TW'(1);
      end
`endif
    end
  end

endmodule

// File: tb/tb_ps2_keycode_rx.sv
// tb_ps2_keycode_rx
//   Scoreboard bench for ps2_keycode_rx. The stimulus process drives PS/2
//   frames on the raw pins and pushes the expected outcome of each frame
//   (good byte with resulting keycode, or dropped frame) into a queue; an
//   independent monitor pops one entry for every rx_valid / frame_err
//   pulse. Timeout checks are compiled only with PS2_TIMEOUT_EN.
module tb_ps2_keycode_rx;

  localparam int unsigned FL   = 8;
  localparam int unsigned TO   = 100;
  localparam int unsigned HALF = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [15:0] keycode;
  logic        rx_valid;
  logic        frame_err;

  ps2_keycode_rx #(
    .FILTER_LEN    (FL),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .keycode  (keycode),
    .rx_valid (rx_valid),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_err;
    logic [15:0] kc;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  bit   prev_pulse = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: one scoreboard entry per output pulse.
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid || frame_err) begin
        check("pulse_exclusive", {31'd0, rx_valid & frame_err}, 32'd0);
        check("pulse_single_cycle", {31'd0, prev_pulse}, 32'd0);
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_pulse: rx_valid=%0b frame_err=%0b keycode=%h, expected no pulse",
                   rx_valid, frame_err, keycode);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("pulse_kind_err", {31'd0, frame_err}, {31'd0, e.is_err});
          check("pulse_keycode", {16'd0, keycode}, {16'd0, e.kc});
        end
      end
      prev_pulse = rx_valid | frame_err;
    end else begin
      prev_pulse = 1'b0;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input bit b);
    ps2_data = b;
    cycles(HALF);
    ps2_clk = 1'b0;
    cycles(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit par, input bit stop,
                            input bit exp_err, input logic [15:0] exp_kc);
    exp_t e;
    e.is_err = exp_err;
    e.kc     = exp_kc;
    sb.push_back(e);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(par);
    send_bit(stop);
    ps2_data = 1'b1;
    cycles(HALF);
    check("keycode_after_frame", {16'd0, keycode}, {16'd0, exp_kc});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycles(3);
    rst = 1'b0;
    cycles(2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    cycles(4);
    check("reset_keycode", {16'd0, keycode}, 32'd0);
    check("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("reset_frame_err", {31'd0, frame_err}, 32'd0);
    rst = 1'b0;
    cycles(5);

    // Single make code.
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0, 16'h001C);

    // Break sequence F0 1C from a clean keycode.
    do_reset();
    check("keycode_after_reset", {16'd0, keycode}, 32'd0);
    send_frame(8'hF0, 1'b1, 1'b1, 1'b0, 16'h00F0);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0, 16'hF01C);

    // Bad parity is dropped, next good byte shifts in.
    send_frame(8'h1C, 1'b1, 1'b1, 1'b1, 16'hF01C);
    send_frame(8'h29, 1'b0, 1'b1, 1'b0, 16'h1C29);

    // Short glitch is filtered; long low with data high is a spurious edge.
    ps2_clk = 1'b0;
    cycles(FL - 1);
    ps2_clk = 1'b1;
    cycles(HALF);
    ps2_data = 1'b1;
    ps2_clk  = 1'b0;
    cycles(FL + 2);
    ps2_clk = 1'b1;
    cycles(HALF);
    check("keycode_after_glitch", {16'd0, keycode}, 32'h0000_1C29);
    send_frame(8'h29, 1'b0, 1'b1, 1'b0, 16'h2929);

    // Missing stop bit is dropped.
    send_frame(8'h45, 1'b0, 1'b0, 1'b1, 16'h2929);

    // Reset mid-frame: partial bits must not leak into the next byte.
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    do_reset();
    check("keycode_after_midframe_reset", {16'd0, keycode}, 32'd0);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0, 16'h001C);

`ifdef PS2_TIMEOUT_EN
    begin
      exp_t e;
      int   n;
      bit   seen;
      e.is_err = 1'b1;
      e.kc     = 16'h001C;
      sb.push_back(e);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      ps2_data = 1'b1;
      cycles(HALF);
      ps2_clk = 1'b0;
      n    = 0;
      seen = 1'b0;
      while (!seen && n < 1000) begin
        @(negedge clk);
        n++;
        if (n == HALF) ps2_clk = 1'b1;
        if (frame_err) seen = 1'b1;
      end
      ps2_clk = 1'b1;
      // raw edge -> fe takes 2 + FL cycles, then TO idle cycles.
      check("timeout_latency", n, 2 + FL + TO);
      cycles(HALF);
      send_frame(8'h1C, 1'b0, 1'b1, 1'b0, 16'h1C1C);
    end
`endif

    cycles(50);
    check("scoreboard_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
